shift_left_restoring_divider: RTL and testbench

//   Sequential unsigned restoring divider, the inverse datapath of the shift-add

---
 rtl/shift_left_restoring_divider.sv | 121 ++++++++++++
 tb/tb_shift_left_restoring_divider.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/shift_left_restoring_divider.sv
// Sequential unsigned restoring divider. It retires one quotient bit per clock
// by shifting {R,Q} left and doing a trial subtract of D against the (N+1)-bit R.
module shift_left_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  // R stays below D between steps, so N stored bits are enough; only the
  // shifted trial value needs the extra bit.
  logic [N-1:0]   r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     r_sh, r_trial, r_step;
  logic [N-1:0]   q_step;
  logic           ge;

  // one restoring step
  always_comb begin
    r_sh    = {r_q, q_q[N-1]};
    ge      = (r_sh >= {1'b0, d_q});
    r_trial = r_sh - {1'b0, d_q};
    r_step  = ge ? r_trial : r_sh;
    q_step  = {q_q[N-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = r_step[N-1:0];
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          quot_d  = q_step;
          rem_d   = r_step[N-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_shift_left_restoring_divider.sv
// Directed and swept checks for the restoring divider: latency, busy/done
// handshake, divide-by-zero, ignored start, async reset, back-to-back.
module tb_shift_left_restoring_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_chk  = 0;
  int n_pass = 0;

  shift_left_restoring_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Call at #1 after an edge; returns edges until done is seen and busy cycles.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic edbz, input int elat);
    int lat, bcyc;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = N'($urandom); divisor = N'($urandom);
    wait_done(lat, bcyc);
    check({tag, "_lat"},  lat, elat);
    check({tag, "_busy"}, bcyc, elat);
    check({tag, "_q"},    quotient, eq);
    check({tag, "_r"},    remainder, er);
    check({tag, "_dbz"},  div_by_zero, edbz);
    if (b != 0) begin
      check({tag, "_inv"},  32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check({tag, "_rltd"}, 32'(remainder < b), 32'd1);
    end
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_hold"},  quotient, eq);
  endtask

  initial begin
    int lat, bcyc;
    logic [N-1:0] a, b;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("rst_q",    quotient, 0);
    check("rst_r",    remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz",  div_by_zero, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    run_op("d5_9",   8'd5,   8'd9, 8'd0, 8'd5, 1'b0, 8);
    run_op("d0_3",   8'd0,   8'd3, 8'd0, 8'd0, 1'b0, 8);
    run_op("dbz",    8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 0);

    // start during RUN is ignored; previous results held mid-run
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ign_hold_q",   quotient, 255);
    check("ign_hold_dbz", div_by_zero, 1);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_hold_r", remainder, 200);
    wait_done(lat, bcyc);
    check("ign_lat", lat, 5);
    check("ign_q",   quotient, 14);
    check("ign_r",   remainder, 2);
    check("ign_dbz", div_by_zero, 0);
    @(posedge clk); #1;

    // async reset mid-run
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q",    quotient, 0);
    check("arst_r",    remainder, 0);
    check("arst_dbz",  div_by_zero, 0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", busy, 0);
    run_op("d9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 8);

    // back-to-back with start held high
    start = 1'b1; dividend = 8'd200; divisor = 8'd13;
    @(posedge clk); #1;
    dividend = 8'd17; divisor = 8'd4;
    wait_done(lat, bcyc);
    check("b2b1_lat", lat, 8);
    check("b2b1_q",   quotient, 15);
    check("b2b1_r",   remainder, 5);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_rerun", busy, 1);
    wait_done(lat, bcyc);
    check("b2b2_gap", lat + 1, 9);
    check("b2b2_q",   quotient, 4);
    check("b2b2_r",   remainder, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(1, 255));
      run_op("rnd", a, b, a / b, a % b, 1'b0, 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
